// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access encodings,
// FSM states and the legality check for a captured request.
package mem_pkg;

  // RV32 funct3 access types on MemOp
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // dir: 1 = store, 0 = load. Unsigned variants exist only for loads.
  function automatic logic is_legal(input logic [2:0] op, input logic dir,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (op)
      MEM_B:   ok = 1'b1;
      MEM_H:   ok = ~addr_lo[0];
      MEM_W:   ok = (addr_lo == 2'b00);
      MEM_BU:  ok = ~dir;
      MEM_HU:  ok = ~dir & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Load alignment and extension: selects the addressed byte/halfword out of
// a 32-bit word and sign- or zero-extends it. Purely combinational.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed byte and halfword lanes
  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // extend the selected lane according to the access type
  always_comb begin
    data_o = word_i;
    case (op_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_BU:  data_o = {24'd0, byte_sel};
      MEM_HU:  data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port. Captures one load/store,
// optionally stalls WAIT_STATES cycles, performs the array access, then
// strobes MemReady (and MemFault for illegal requests) for one cycle.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for MemRead|MemWrite; request captured on entry
// ST_WAIT   | inserted wait cycles, down-counter to terminal count 0
// ST_ACCESS | store commits / load data registered at end of cycle
// ST_RESP   | MemReady (and MemFault if illegal) for one cycle
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAddr,
  input  logic [2:0]  MemOp,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemReadDataOut,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemFault,
  output logic [31:0] FaultAddr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] faddr_q, faddr_d;
  logic [2:0]  op_q, op_d;
  logic        wr_q, wr_d;
  logic        both_q, both_d;

  logic          req;
  logic          legal;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   ext_word;
  logic [31:0]   wr_lanes;
  logic [3:0]    be;

  logic [31:0] mem_array [DEPTH_WORDS];

  assign req     = MemRead | MemWrite;
  assign idx     = addr_q[AW+1:2];
  assign legal   = ~both_q & is_legal(op_q, wr_q, addr_q[1:0]);
  assign rd_word = mem_array[idx];

  load_extend u_load_extend (
    .word_i    (rd_word),
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op_q),
    .data_o    (ext_word)
  );

  // state and datapath registers; array contents are deliberately not reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      faddr_q <= 32'd0;
      op_q    <= 3'd0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      faddr_q <= faddr_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
    end
  end

  // next-state logic and wait-state down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // request capture in IDLE; load data / fault address update in ACCESS
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    wr_d    = wr_q;
    both_d  = both_q;
    rdata_d = rdata_q;
    faddr_d = faddr_q;
    if (state_q == ST_IDLE && req) begin
      addr_d  = DataAddr;
      wdata_d = MemDataIn;
      op_d    = MemOp;
      wr_d    = MemWrite;
      both_d  = MemRead & MemWrite;
    end
    if (state_q == ST_ACCESS) begin
      if (!legal)     faddr_d = addr_q;
      else if (!wr_q) rdata_d = ext_word;
    end
  end

  // byte-lane enables and lane-replicated store data, only for a legal store in ACCESS
  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata_q;
    case (op_q)
      MEM_B: begin
        be       = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      MEM_H: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(state_q == ST_ACCESS && wr_q && legal)) be = 4'b0000;
  end

  // array write port; unselected lanes keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_array[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
    end
  end

  // outputs decoded from state and registered data
  always_comb begin
    MemReady       = (state_q == ST_RESP);
    MemFault       = (state_q == ST_RESP) & ~legal;
    MemBusy        = req & ~MemReady;
    MemReadDataOut = rdata_q;
    FaultAddr      = faddr_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. Three instances (WAIT_STATES 0, 3, 2)
// share the clock and reset; 'sel' routes requests to one of them. The driver
// pushes hand-computed responses and checks latency/MemBusy; the monitor pops
// and compares whenever the selected instance raises MemReady.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] addr, wdata;
  logic [2:0]  op;
  logic        rd, wr;
  int          sel;

  logic [31:0] rdo [3];
  logic [31:0] fa  [3];
  logic        rdy [3];
  logic        busy[3];
  logic        flt [3];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset), .DataAddr(addr), .MemOp(op),
    .MemRead(rd & (sel == 0)), .MemWrite(wr & (sel == 0)), .MemDataIn(wdata),
    .MemReadDataOut(rdo[0]), .MemReady(rdy[0]), .MemBusy(busy[0]),
    .MemFault(flt[0]), .FaultAddr(fa[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset), .DataAddr(addr), .MemOp(op),
    .MemRead(rd & (sel == 1)), .MemWrite(wr & (sel == 1)), .MemDataIn(wdata),
    .MemReadDataOut(rdo[1]), .MemReady(rdy[1]), .MemBusy(busy[1]),
    .MemFault(flt[1]), .FaultAddr(fa[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .reset(reset), .DataAddr(addr), .MemOp(op),
    .MemRead(rd & (sel == 2)), .MemWrite(wr & (sel == 2)), .MemDataIn(wdata),
    .MemReadDataOut(rdo[2]), .MemReady(rdy[2]), .MemBusy(busy[2]),
    .MemFault(flt[2]), .FaultAddr(fa[2])
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [31:0] faddr;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: compare every response of the selected instance against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && rdy[sel] === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got MemReady=1 expected no response (inst %0d)", sel);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_data"},  rdo[sel], e.data);
        chk({e.name, "_fault"}, {31'd0, flt[sel]}, {31'd0, e.fault});
        chk({e.name, "_faddr"}, fa[sel], e.faddr);
      end
    end
  end

  // issue one request starting at a negedge (cycle 0); checks latency and MemBusy
  task automatic do_req(input string name, input logic r, input logic w,
                        input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] edata, input logic efault,
                        input logic [31:0] efa);
    exp_t e;
    bit   done;
    e.data = edata; e.fault = efault; e.faddr = efa; e.name = name;
    sbq.push_back(e);
    rd = r; wr = w; op = o; addr = a; wdata = d;
    done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (rdy[sel] === 1'b1) begin
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        chk({name, "_busy_at_ready"}, {31'd0, busy[sel]}, 32'd0);
        done = 1'b1;
      end else begin
        chk({name, "_busy"}, {31'd0, busy[sel]}, 32'd1);
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no MemReady expected one at cycle %0d", name, lat);
      void'(sbq.pop_back());
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; rd = 1'b0; wr = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_data",  rdo[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_data",  rdo[0], 32'd0);
    chk("post_rst_faddr", fa[0], 32'd0);
    chk("post_rst_fault", {31'd0, flt[0]}, 32'd0);

    // WAIT_STATES = 0 instance
    do_req("sw_100",  0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0,        0, 32'h0);
    do_req("lw_100",  1, 0, 3'b010, 32'h100, 32'h0,        2, 32'hDEADBEEF, 0, 32'h0);
    do_req("sb_101",  0, 1, 3'b000, 32'h101, 32'h0000005A, 2, 32'hDEADBEEF, 0, 32'h0);
    do_req("lb_101",  1, 0, 3'b000, 32'h101, 32'h0,        2, 32'h0000005A, 0, 32'h0);
    do_req("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0,        2, 32'h000000DE, 0, 32'h0);
    do_req("lh_102",  1, 0, 3'b001, 32'h102, 32'h0,        2, 32'hFFFFDEAD, 0, 32'h0);
    do_req("lw_100b", 1, 0, 3'b010, 32'h100, 32'h0,        2, 32'hDEAD5AEF, 0, 32'h0);
    do_req("sw_0",    0, 1, 3'b010, 32'h0,   32'h12345678, 2, 32'hDEAD5AEF, 0, 32'h0);
    do_req("f_lw102", 1, 0, 3'b010, 32'h102, 32'h0,        2, 32'hDEAD5AEF, 1, 32'h102);
    do_req("f_sh103", 0, 1, 3'b001, 32'h103, 32'h0000FFFF, 2, 32'hDEAD5AEF, 1, 32'h103);
    do_req("f_op011", 1, 0, 3'b011, 32'h0,   32'h0,        2, 32'hDEAD5AEF, 1, 32'h0);
    do_req("f_rdwr",  1, 1, 3'b010, 32'h0,   32'hFFFFFFFF, 2, 32'hDEAD5AEF, 1, 32'h0);
    do_req("lw_100c", 1, 0, 3'b010, 32'h100, 32'h0,        2, 32'hDEAD5AEF, 0, 32'h0);
    do_req("lhu_102", 1, 0, 3'b101, 32'h102, 32'h0,        2, 32'h0000DEAD, 0, 32'h0);
    do_req("lb_103",  1, 0, 3'b000, 32'h103, 32'h0,        2, 32'hFFFFFFDE, 0, 32'h0);
    do_req("sh_102",  0, 1, 3'b001, 32'h102, 32'h0000BEEF, 2, 32'hFFFFFFDE, 0, 32'h0);
    do_req("lw_100d", 1, 0, 3'b010, 32'h100, 32'h0,        2, 32'hBEEF5AEF, 0, 32'h0);
    do_req("lw_0",    1, 0, 3'b010, 32'h0,   32'h0,        2, 32'h12345678, 0, 32'h0);
    do_req("sw_0b",   0, 1, 3'b010, 32'h0,   32'hCAFEF00D, 2, 32'h12345678, 0, 32'h0);
    do_req("lw_1000", 1, 0, 3'b010, 32'h1000, 32'h0,       2, 32'hCAFEF00D, 0, 32'h0);

    // WAIT_STATES = 3 instance: back-to-back requests, second accepted in cycle 6
    sel = 1;
    do_req("w3_sw_0",  0, 1, 3'b010, 32'h0, 32'hA5A5A5A5, 5, 32'h0,        0, 32'h0);
    do_req("w3_lw_0",  1, 0, 3'b010, 32'h0, 32'h0,        5, 32'hA5A5A5A5, 0, 32'h0);
    do_req("w3_lb_2",  1, 0, 3'b000, 32'h2, 32'h0,        5, 32'hFFFFFFA5, 0, 32'h0);

    // WAIT_STATES = 2 instance: store abandoned by reset during WAIT
    sel = 2;
    do_req("w2_sw_200", 0, 1, 3'b010, 32'h200, 32'h22222222, 4, 32'h0, 0, 32'h0);
    rd = 1'b0; wr = 1'b1; op = 3'b010; addr = 32'h200; wdata = 32'h11111111;
    repeat (2) @(negedge clk);
    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_mid_ready", {31'd0, rdy[2]}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_data",  rdo[2], 32'd0);
    chk("rst_mid_faddr", fa[2], 32'd0);
    chk("rst_mid_fault", {31'd0, flt[2]}, 32'd0);
    @(negedge clk);
    do_req("w2_lw_200", 1, 0, 3'b010, 32'h200, 32'h0, 4, 32'h22222222, 0, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the RiscvCore data port.
- Accepts the core's load/store requests (DataAddr, MemOp, MemRead, MemWrite, MemDataIn) and owns a word-organised SRAM array.
- Applies byte-lane write enables, aligns and sign/zero-extends load data, and inserts configurable wait states.
- Reports misaligned or illegal requests, replacing the zero-latency DataMemory.

Parameters:
- DEPTH_WORDS, 1024: array depth in 32-bit words; power of two.
- WAIT_STATES, 0: extra cycles between acceptance and the array access (0..15).
- AW, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- DataAddr  in  32  byte address
- MemOp  in  3  RV32 funct3 access type
- MemRead  in  1  load request
- MemWrite  in  1  store request
- MemDataIn  in  32  store data, LSB-aligned
- MemReadDataOut  out  32  extended load data
- MemReady  out  1  one-cycle response strobe
- MemBusy  out  1  stall to core
- MemFault  out  1  one-cycle fault strobe, coincident with MemReady
- FaultAddr  out  32  DataAddr of the most recent faulting request

Behaviour:
- Interface decisions:
  - One clock, clk.
  - reset is asynchronous and active-high. It forces state IDLE; MemReadDataOut=0, MemReady=0, MemFault=0, FaultAddr=0, wait counter=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - A request (MemRead|MemWrite) is sampled at the clock edge into address, op, data and dir registers.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter counts WAIT_STATES cycles, then ACCESS.
- ACCESS:
  - A legal store commits to the array at the end-of-cycle edge.
  - A legal load reads the array synchronously, with extended data registered at the same edge.
  - Next state is RESP.
- RESP:
  - MemReady=1 for exactly one cycle, then IDLE.
  - Request inputs are ignored in WAIT/ACCESS/RESP.
  - The next request can be accepted on the cycle after RESP.
- Latency: request present in cycle 0 gives MemReady in cycle 2+WAIT_STATES.
- MemBusy = (MemRead|MemWrite) & ~MemReady, combinational. The core holds the request stable until MemReady.
- Address mapping:
  - Word index = DataAddr[AW+1:2].
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Legal ops:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Faults:
  - Fault conditions: any other MemOp value; H with addr[0]=1; W with addr[1:0]!=0; MemRead&MemWrite together.
  - On a fault: no array write, MemReadDataOut unchanged, MemFault=1 in the RESP cycle.
  - FaultAddr is loaded with the captured address. It is sticky until the next fault.
- Store lanes:
  - SB writes MemDataIn[7:0] to lane addr[1:0].
  - SH writes MemDataIn[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes. Unselected lanes are preserved.
- Load extension:
  - Byte is selected by addr[1:0]; halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- MemReadDataOut changes only on a legal load response and holds otherwise, including across stores.
- A load that follows a store to the same word returns the stored data, because the commit precedes the next ACCESS.
- Reset mid-operation:
  - A store abandoned before its ACCESS edge never commits.
  - No MemReady is generated for the abandoned request.

Decomposition:
- Package mem_pkg holds:
  - MemOp encodings: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
  - FSM state enum.
  - Function is_legal(op, dir, addr_lo).
- Sub-module load_extend is combinational: word, addr[1:0] and op in, 32-bit extended data out. It is reused by any future cache.
- Byte-enable generation and the FSM stay in dmem_responder.

Test Plan:
1. SW 0xDEADBEEF @0x100, then LW @0x100. Response: MemReady at cycle 2 of each request (WAIT_STATES=0); MemReadDataOut=0xDEADBEEF; MemFault=0.
2. After test 1, SB 0x5A @0x101, then LB @0x101, LBU @0x103, LH @0x102. Responses: 0x0000005A, 0x000000DE, 0xFFFFDEAD; word 0x100 reads back 0xDEAD5AEF.
3. WAIT_STATES=3, LW @0x0. Response: MemBusy high for cycles 0-4; MemReady only in cycle 5; next request accepted in cycle 6.
4. LW @0x102, SH @0x103, MemOp=3'b011 load @0x0, and MemRead&MemWrite @0x0, each applied separately. Each gives a MemFault pulse with MemReady; FaultAddr equals the last faulting address (0x0); array and MemReadDataOut unchanged.
5. Assert reset during WAIT of an SW 0x11111111 @0x200 (WAIT_STATES=2); release; LW @0x200. Response: old contents returned; no MemReady during reset; outputs 0 after reset.
6. SW 0xCAFEF00D @0x0 with DEPTH_WORDS=1024, then LW @0x1000. Response: 0xCAFEF00D, confirming address wrap.
